serial_transmitter: RTL and testbench

- UART-style 8N1 serial transmitter. It is the outbound counterpart of the robot's serial receiver.
- Sends status/telemetry bytes (sensor states, enable, acknowledgements) from the robot back to the host on a single serial line.
- Contains a small byte FIFO so the control logic can queue short messages without waiting on the line.
- Sits in the top level beside the receiver, on the same 50 MHz clock and shared reset.

---
 rtl/serial_transmitter_if.sv | 29 ++
 rtl/serial_transmitter.sv | 179 +++++++++++++++++
 tb/tb_serial_transmitter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmitter_if
// Description : Byte-queue and serial-line bundle for the 8N1 transmitter.
//               The master side is the control logic that queues bytes.
//               The slave side is the transmitter itself.
// Revision    : 1.0  initial release
// ============================================================================
interface serial_transmitter_if;
  logic [7:0] txData;
  logic       txWrite;
  logic       txFull;
  logic       txEmpty;
  logic       txBusy;
  logic       txDone;
  logic       txOverflow;
  logic       serialOutput;

  modport master (
    output txData, txWrite,
    input  txFull, txEmpty, txBusy, txDone, txOverflow, serialOutput
  );

  modport slave (
    input  txData, txWrite,
    output txFull, txEmpty, txBusy, txDone, txOverflow, serialOutput
  );
endinterface
`default_nettype wire

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmitter
// Description : UART-style 8N1 transmitter with a small byte FIFO. Frames
//               are sent back to back while bytes remain queued.
// Revision    : 1.0  initial release
// ============================================================================
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_transmitter_if.slave  tx_if
);

  localparam int              c_cw        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int              c_aw        = $clog2(FIFO_DEPTH);
  localparam logic [c_cw-1:0] c_baud_last = c_cw'(CLKS_PER_BIT - 1);
  localparam logic [c_aw:0]   c_full_cnt  = (c_aw + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [c_cw-1:0] baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_q, line_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]   count_q, count_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_baud_last;

  // Flags come straight from the count register so they are glitch-free.
  assign w_full      = (count_q == c_full_cnt);
  assign w_empty     = (count_q == '0);
  assign w_push      = tx_if.txWrite && !w_full;
  assign w_baud_last = (baud_q == c_baud_last);

  assign tx_if.txFull       = w_full;
  assign tx_if.txEmpty      = w_empty;
  assign tx_if.txBusy       = (state_q != ST_IDLE);
  assign tx_if.txDone       = (state_q == ST_STOP) && w_baud_last;
  assign tx_if.txOverflow   = ovf_q;
  assign tx_if.serialOutput = line_q;

  // Frame sequencer: next state, baud/bit counters and the next line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    line_d    = line_q;
    w_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          line_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          line_d    = shift_q[0];
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            line_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            line_d    = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more bytes wait.
          if (!w_empty) begin
            w_pop   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            line_d  = 1'b0;
            state_d = ST_START;
          end else begin
            line_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        line_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Byte queue: full is judged before any same-cycle pop, so a write while full is lost.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = tx_if.txWrite && w_full;
    if (w_push) begin
      mem_d[wr_ptr_q] = tx_if.txData;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset aborts any frame and drops queued bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      line_q    <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_q     <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_transmitter
// Description : Directed self-checking bench for serial_transmitter with
//               CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_transmitter;

  logic clk = 1'b0;
  logic rst;

  serial_transmitter_if tx_if();

  serial_transmitter #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (tx_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit 0 = start bit, bits 8:1 = data LSB first, bit 9 = stop
  } vec_t;

  vec_t       vt [5];
  logic [9:0] frm [0:4];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample k is taken 1 ns after edge (pop edge + k); frames of 40 cycles each.
  task automatic check_stream(input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      chk($sformatf("line k=%0d", k), tx_if.serialOutput, frm[k / 40][(k % 40) / 4]);
      chk($sformatf("busy k=%0d", k), tx_if.txBusy, 1);
      chk($sformatf("done k=%0d", k), tx_if.txDone, ((k % 40) == 39) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    vt[0] = '{8'hA5, 10'b1101001010};
    vt[1] = '{8'h3C, 10'b1001111000};
    vt[2] = '{8'h00, 10'b1000000000};
    vt[3] = '{8'hFF, 10'b1111111110};
    vt[4] = '{8'h81, 10'b1100000010};

    rst           = 1'b1;
    tx_if.txData  = 8'h00;
    tx_if.txWrite = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst line", tx_if.serialOutput, 1);
    chk("rst busy", tx_if.txBusy, 0);
    chk("rst empty", tx_if.txEmpty, 1);
    chk("rst full", tx_if.txFull, 0);
    chk("rst done", tx_if.txDone, 0);
    chk("rst ovf", tx_if.txOverflow, 0);
    #2 rst = 1'b0;

    // Idle with no writes
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle done", tx_if.txDone, 0);
      chk("idle line", tx_if.serialOutput, 1);
    end
    chk("idle busy", tx_if.txBusy, 0);
    chk("idle empty", tx_if.txEmpty, 1);

    // Single-byte frames from the table
    for (int i = 0; i < 5; i++) begin
      frm[0]        = vt[i].line;
      tx_if.txData  = vt[i].data;
      tx_if.txWrite = 1'b1;
      step();
      tx_if.txWrite = 1'b0;
      chk("single empty after write", tx_if.txEmpty, 0);
      chk("single line before pop", tx_if.serialOutput, 1);
      step();
      check_stream(0, 40);
      chk("single busy end", tx_if.txBusy, 0);
      chk("single line end", tx_if.serialOutput, 1);
      chk("single empty end", tx_if.txEmpty, 1);
    end

    // Back-to-back frames
    frm[0] = 10'b1000000010;
    frm[1] = 10'b1000000100;
    frm[2] = 10'b1000000110;
    tx_if.txData  = 8'h01;
    tx_if.txWrite = 1'b1;
    step();
    tx_if.txData = 8'h02;
    step();
    tx_if.txData = 8'h03;
    step();
    tx_if.txWrite = 1'b0;
    check_stream(1, 79);
    chk("b2b empty before 3rd pop", tx_if.txEmpty, 0);
    check_stream(79, 80);
    chk("b2b empty after 3rd pop", tx_if.txEmpty, 1);
    check_stream(80, 120);
    chk("b2b busy end", tx_if.txBusy, 0);

    // Fill and overflow during a frame
    frm[0] = 10'b1110000110;
    frm[1] = 10'b1000100000;
    frm[2] = 10'b1000100010;
    frm[3] = 10'b1000100100;
    frm[4] = 10'b1000100110;
    tx_if.txData  = 8'hC3;
    tx_if.txWrite = 1'b1;
    step();
    tx_if.txWrite = 1'b0;
    step();
    check_stream(0, 10);
    for (int i = 0; i < 5; i++) begin
      tx_if.txData  = 8'h10 + 8'(i);
      tx_if.txWrite = 1'b1;
      step();
      chk($sformatf("ovf full after write %0d", i + 1), tx_if.txFull, (i >= 3) ? 1 : 0);
      chk($sformatf("ovf pulse after write %0d", i + 1), tx_if.txOverflow, (i == 4) ? 1 : 0);
    end
    tx_if.txWrite = 1'b0;
    step();
    chk("ovf pulse cleared", tx_if.txOverflow, 0);
    chk("ovf still full", tx_if.txFull, 1);
    check_stream(16, 200);
    chk("ovf busy end", tx_if.txBusy, 0);
    chk("ovf empty end", tx_if.txEmpty, 1);
    chk("ovf full end", tx_if.txFull, 0);

    // Reset in the middle of data bit 3
    frm[0] = 10'b1111111110;
    tx_if.txData  = 8'hFF;
    tx_if.txWrite = 1'b1;
    step();
    tx_if.txData = 8'h00;
    step();
    tx_if.txWrite = 1'b0;
    check_stream(0, 17);
    #1 rst = 1'b1;
    #1;
    chk("midrst line", tx_if.serialOutput, 1);
    chk("midrst busy", tx_if.txBusy, 0);
    chk("midrst empty", tx_if.txEmpty, 1);
    #2 rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("postrst line", tx_if.serialOutput, 1);
      chk("postrst busy", tx_if.txBusy, 0);
    end
    chk("postrst empty", tx_if.txEmpty, 1);

    // Write on the same cycle as a pop with one byte queued
    frm[0] = 10'b1001111000;
    frm[1] = 10'b1010110100;
    frm[2] = 10'b1010101010;
    tx_if.txData  = 8'h3C;
    tx_if.txWrite = 1'b1;
    step();
    tx_if.txData = 8'h5A;
    step();
    tx_if.txWrite = 1'b0;
    check_stream(0, 39);
    chk("wp count1 before", tx_if.txEmpty, 0);
    tx_if.txData  = 8'h55;
    tx_if.txWrite = 1'b1;
    check_stream(39, 40);
    tx_if.txWrite = 1'b0;
    chk("wp not empty", tx_if.txEmpty, 0);
    chk("wp not full", tx_if.txFull, 0);
    check_stream(40, 120);
    chk("wp busy end", tx_if.txBusy, 0);
    chk("wp empty end", tx_if.txEmpty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
